branch_fu_arbiter: RTL and testbench

BRANCH_FU_ARBITER -- requirements
Module: branch_fu_arbiter

---
 rtl/branch_fu_arbiter_pkg.sv | 23 ++
 rtl/branch_fu_arbiter_rr_picker.sv | 31 +++
 rtl/branch_fu_arbiter.sv | 111 +++++++++++
 tb/tb_branch_fu_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_fu_arbiter_pkg.sv
// Shared types for the branch FU issue arbiter.
// Packet layout and arbiter state encoding.
package branch_fu_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  br_func;
    logic [5:0]  rob_idx;
  } ISSUE_FU_PACKET;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/branch_fu_arbiter_rr_picker.sv
// Round-robin pick: first requester at or after ptr,
// wrapping modulo N.
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic found;
  int   slot;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    slot  = 0;
    for (int i = 0; i < N; i++) begin
      slot = (int'(ptr) + i) % N;
      if (!found && req[slot]) begin
        found     = 1'b1;
        gnt[slot] = 1'b1;
        idx       = PW'(slot);
      end
    end
  end

endmodule

// File: rtl/branch_fu_arbiter.sv
// Branch FU issue arbiter with one-entry output register.
// Optional perf counters: define BRANCH_ARB_PERF_EN.
module branch_fu_arbiter
  import branch_fu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   issue_valid,
  input  ISSUE_FU_PACKET       issue_packet [NUM_REQ],
  output logic [NUM_REQ-1:0]   issue_grant,
  output ISSUE_FU_PACKET       fu_packet_out,
  input  logic                 fu_ready,
  input  logic                 complete_stall,
  input  logic                 squash,
  output logic                 arb_busy
`ifdef BRANCH_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]     grant_cnt [NUM_REQ],
  output logic [CNT_W-1:0]     hold_cnt
`endif
);

  localparam int PW = ptr_w(NUM_REQ);

  ISSUE_FU_PACKET oreg_q;
  ISSUE_FU_PACKET oreg_d;
  logic [PW-1:0]  rr_ptr_q;
  logic [PW-1:0]  rr_ptr_d;
  arb_state_e     state;
  logic           adv;
  logic           any_req;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [PW-1:0]  pick_idx;

  rr_picker #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req (issue_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    state = IDLE;
    if (oreg_q.valid) begin
      state = (fu_ready && !complete_stall) ? SEND : HOLD;
    end
  end

  assign adv     = (state != HOLD);
  assign any_req = |issue_valid;

  // Grant is suppressed while held in reset so nothing looks accepted.
  assign issue_grant = (adv && !squash && reset) ? pick_gnt : '0;

  always_comb begin
    oreg_d   = oreg_q;
    rr_ptr_d = rr_ptr_q;
    unique case (1'b1)
      squash: begin
        oreg_d = '0;
      end
      (!squash && adv && any_req): begin
        oreg_d       = issue_packet[pick_idx];
        oreg_d.valid = 1'b1;
        rr_ptr_d     = (pick_idx == PW'(NUM_REQ - 1))
                     ? '0 : pick_idx + 1'b1;
      end
      (!squash && adv && !any_req): begin
        oreg_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      oreg_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      oreg_q   <= oreg_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Empty OREG is all zeros, so valid is already forced low.
  assign fu_packet_out = oreg_q;
  assign arb_busy      = oreg_q.valid;

`ifdef BRANCH_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      hold_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (issue_grant[i] && (grant_cnt[i] != '1))
          grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
      if ((state == HOLD) && (hold_cnt != '1))
        hold_cnt <= hold_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_fu_arbiter.sv
// Self-checking bench for branch_fu_arbiter.
// Scoreboard of granted packets checked at FU consumption.
module tb_branch_fu_arbiter;
  import branch_fu_arbiter_pkg::*;

  localparam int N = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   issue_valid = '0;
  ISSUE_FU_PACKET issue_packet [N];
  logic [N-1:0]   issue_grant;
  ISSUE_FU_PACKET fu_packet_out;
  logic           fu_ready = 1'b1;
  logic           complete_stall = 1'b0;
  logic           squash = 1'b0;
  logic           arb_busy;

  int checks   = 0;
  int failures = 0;
  ISSUE_FU_PACKET sb [$];
  ISSUE_FU_PACKET mexp;

`ifdef BRANCH_ARB_PERF_EN
  logic [15:0]    grant_cnt [N];
  logic [15:0]    hold_cnt;
  logic [N-1:0]   g2;
  ISSUE_FU_PACKET o2;
  logic           b2;
  logic [1:0]     gc2 [N];
  logic [1:0]     hc2;
`endif

  branch_fu_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_packet   (issue_packet),
    .issue_grant    (issue_grant),
    .fu_packet_out  (fu_packet_out),
    .fu_ready       (fu_ready),
    .complete_stall (complete_stall),
    .squash         (squash),
    .arb_busy       (arb_busy)
`ifdef BRANCH_ARB_PERF_EN
    ,
    .grant_cnt      (grant_cnt),
    .hold_cnt       (hold_cnt)
`endif
  );

`ifdef BRANCH_ARB_PERF_EN
  branch_fu_arbiter #(.NUM_REQ(N), .CNT_W(2)) dut_sat (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_packet   (issue_packet),
    .issue_grant    (g2),
    .fu_packet_out  (o2),
    .fu_ready       (fu_ready),
    .complete_stall (complete_stall),
    .squash         (squash),
    .arb_busy       (b2),
    .grant_cnt      (gc2),
    .hold_cnt       (hc2)
  );
`endif

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Consumption point: packet leaves OREG at the next rising edge.
  always @(negedge clock) begin
    if (reset && squash) begin
      sb.delete();
    end else if (reset && fu_packet_out.valid && fu_ready && !complete_stall) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_extra got pc=%h expected none", fu_packet_out.pc);
      end else begin
        mexp = sb.pop_front();
        if (fu_packet_out !== mexp) begin
          failures++;
          $display("FAIL sb_pkt got pc=%h imm=%h expected pc=%h imm=%h",
                   fu_packet_out.pc, fu_packet_out.imm, mexp.pc, mexp.imm);
        end
      end
    end
  end

  function automatic ISSUE_FU_PACKET mk(input logic [31:0] pc);
    ISSUE_FU_PACKET p;
    p.valid   = 1'b1;
    p.pc      = pc;
    p.imm     = ~pc;
    p.br_func = pc[2:0];
    p.rob_idx = pc[7:2];
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    issue_valid    = '0;
    fu_ready       = 1'b1;
    complete_stall = 1'b0;
    squash         = 1'b0;
    #3;
    sb.delete();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    issue_valid = 2'b11;
    issue_packet[0] = mk(32'h0000_0010);
    issue_packet[1] = mk(32'h0000_0020);
    #2;
    checks++;
    if (issue_grant !== 2'b00) begin
      failures++;
      $display("FAIL rst_grant got %b expected 00", issue_grant);
    end
    checks++;
    if (arb_busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy got %b expected 0", arb_busy);
    end
    tick();
    checks++;
    if (fu_packet_out !== '0) begin
      failures++;
      $display("FAIL rst_out got %h expected 0", fu_packet_out);
    end
    issue_valid = '0;
    reset = 1'b1;
    #1;
    checks++;
    if (issue_grant !== 2'b00) begin
      failures++;
      $display("FAIL rst_idle_grant got %b expected 00", issue_grant);
    end
    sb.delete();
  endtask

  task automatic test_rr_order();
    logic [N-1:0] eg [3];
    logic [31:0]  ep [3];
    eg[0] = 2'b01; eg[1] = 2'b10; eg[2] = 2'b01;
    ep[0] = 32'h0000_0100; ep[1] = 32'h0000_0200; ep[2] = 32'h0000_0100;
    do_reset();
    issue_packet[0] = mk(32'h0000_0100);
    issue_packet[1] = mk(32'h0000_0200);
    issue_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (issue_grant !== eg[c]) begin
        failures++;
        $display("FAIL rr_grant%0d got %b expected %b", c, issue_grant, eg[c]);
      end
      sb.push_back(mk(ep[c]));
      tick();
      checks++;
      if (fu_packet_out.pc !== ep[c] || arb_busy !== 1'b1) begin
        failures++;
        $display("FAIL rr_pc%0d got %h expected %h", c, fu_packet_out.pc, ep[c]);
      end
    end
    issue_valid = '0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    issue_packet[0] = mk(32'h1000_0000);
    issue_packet[1] = mk(32'h2000_0000);
    issue_valid = 2'b01;
    #1;
    sb.push_back(mk(32'h1000_0000));
    tick();
    issue_valid = 2'b11;
    complete_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (issue_grant !== 2'b00 || fu_packet_out.pc !== 32'h1000_0000) begin
        failures++;
        $display("FAIL stall%0d got grant=%b pc=%h expected 00 10000000",
                 c, issue_grant, fu_packet_out.pc);
      end
      tick();
    end
    complete_stall = 1'b0;
    #1;
    checks++;
    if (issue_grant !== 2'b10) begin
      failures++;
      $display("FAIL stall_release got %b expected 10", issue_grant);
    end
    sb.push_back(mk(32'h2000_0000));
    tick();
    issue_valid = '0;
    checks++;
    if (fu_packet_out.pc !== 32'h2000_0000) begin
      failures++;
      $display("FAIL stall_adv got %h expected 20000000", fu_packet_out.pc);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [N-1:0] rq [4];
    logic [N-1:0] eg [4];
    rq[0] = 2'b01; rq[1] = 2'b01; rq[2] = 2'b11; rq[3] = 2'b11;
    eg[0] = 2'b01; eg[1] = 2'b01; eg[2] = 2'b10; eg[3] = 2'b01;
    do_reset();
    issue_packet[0] = mk(32'h0000_3000);
    issue_packet[1] = mk(32'h0000_3100);
    for (int c = 0; c < 4; c++) begin
      issue_valid = rq[c];
      #1;
      checks++;
      if (issue_grant !== eg[c]) begin
        failures++;
        $display("FAIL wrap%0d got %b expected %b", c, issue_grant, eg[c]);
      end
      sb.push_back(eg[c][1] ? mk(32'h0000_3100) : mk(32'h0000_3000));
      tick();
    end
    issue_valid = '0;
    tick();
  endtask

  task automatic test_squash();
    do_reset();
    issue_packet[0] = mk(32'h0000_0300);
    issue_packet[1] = mk(32'h0000_0304);
    issue_valid = 2'b01;
    #1;
    sb.push_back(mk(32'h0000_0300));
    tick();
    complete_stall = 1'b1;
    issue_valid = 2'b11;
    tick();
    squash = 1'b1;
    #1;
    checks++;
    if (issue_grant !== 2'b00) begin
      failures++;
      $display("FAIL squash_grant got %b expected 00", issue_grant);
    end
    tick();
    squash = 1'b0;
    complete_stall = 1'b0;
    checks++;
    if (arb_busy !== 1'b0 || fu_packet_out !== '0) begin
      failures++;
      $display("FAIL squash_flush got busy=%b out=%h expected 0", arb_busy, fu_packet_out);
    end
    #1;
    checks++;
    if (issue_grant !== 2'b10) begin
      failures++;
      $display("FAIL squash_ptr got %b expected 10", issue_grant);
    end
    sb.push_back(mk(32'h0000_0304));
    tick();
    issue_valid = '0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    issue_packet[0] = mk(32'h0000_0400);
    issue_valid = 2'b01;
    #1;
    sb.push_back(mk(32'h0000_0400));
    tick();
    issue_valid = '0;
    complete_stall = 1'b1;
    #1;
    checks++;
    if (arb_busy !== 1'b1) begin
      failures++;
      $display("FAIL async_pre got busy=%b expected 1", arb_busy);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (fu_packet_out.valid !== 1'b0 || arb_busy !== 1'b0) begin
      failures++;
      $display("FAIL async_rst got valid=%b busy=%b expected 0 0",
               fu_packet_out.valid, arb_busy);
    end
    sb.delete();
    complete_stall = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    int           mptr;
    bit           mval;
    bit           adv;
    logic [N-1:0] eg;
    int           k;
    mptr = 0;
    mval = 1'b0;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      issue_valid    = N'($urandom_range(0, (1 << N) - 1));
      fu_ready       = ($urandom_range(0, 3) != 0);
      complete_stall = ($urandom_range(0, 4) == 0);
      for (int s = 0; s < N; s++)
        issue_packet[s] = mk(32'h5000_0000 + 32'(c * 16 + s));
      adv = !mval || (fu_ready && !complete_stall);
      eg  = '0;
      if (adv && (|issue_valid)) begin
        k = -1;
        for (int i = 0; i < N; i++) begin
          if (k < 0 && issue_valid[(mptr + i) % N]) k = (mptr + i) % N;
        end
        eg[k] = 1'b1;
        sb.push_back(issue_packet[k]);
        mptr = (k + 1) % N;
      end
      if (adv) mval = |issue_valid;
      #1;
      checks++;
      if (issue_grant !== eg) begin
        failures++;
        $display("FAIL b2b_grant%0d got %b expected %b", c, issue_grant, eg);
      end
      tick();
    end
    issue_valid    = '0;
    fu_ready       = 1'b1;
    complete_stall = 1'b0;
    for (int c = 0; c < 10 && sb.size() != 0; c++) tick();
    checks++;
    if (sb.size() != 0 || arb_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got left=%0d busy=%b expected 0 0", sb.size(), arb_busy);
    end
  endtask

`ifdef BRANCH_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    issue_packet[1] = mk(32'h0000_0700);
    issue_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      sb.push_back(mk(32'h0000_0700));
      tick();
    end
    issue_valid = '0;
    complete_stall = 1'b1;
    tick();
    tick();
    complete_stall = 1'b0;
    checks++;
    if (grant_cnt[1] !== 16'd5 || grant_cnt[0] !== 16'd0) begin
      failures++;
      $display("FAIL perf_grant got %0d/%0d expected 0/5", grant_cnt[0], grant_cnt[1]);
    end
    checks++;
    if (hold_cnt !== 16'd2) begin
      failures++;
      $display("FAIL perf_hold got %0d expected 2", hold_cnt);
    end
    checks++;
    if (gc2[1] !== 2'd3 || hc2 !== 2'd2) begin
      failures++;
      $display("FAIL perf_sat got %0d/%0d expected 3/2", gc2[1], hc2);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_rr_order();
    test_stall();
    test_wrap();
    test_squash();
    test_async_reset();
    test_back_to_back();
`ifdef BRANCH_ARB_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
